// File: rtl/load_store_unit.sv
// MIPS memory-access stage: byte/halfword loads with extension, sub-word stores via
// read-modify-write on a word-only memory port. Misaligned/out-of-range requests error out.
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_done,
    output logic        resp_error,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_address,
    output logic        mem_write_enable,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    localparam logic [2:0] OpLb  = 3'd0;
    localparam logic [2:0] OpLh  = 3'd1;
    localparam logic [2:0] OpLw  = 3'd2;
    localparam logic [2:0] OpLbu = 3'd3;
    localparam logic [2:0] OpLhu = 3'd4;
    localparam logic [2:0] OpSb  = 3'd5;
    localparam logic [2:0] OpSh  = 3'd6;
    localparam logic [2:0] OpSw  = 3'd7;

    typedef enum logic [2:0] {
        StIdle, StLdRd, StLdExt, StStWr, StRmwRd, StRmwMrg, StDone
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_din_q, mem_din_d;

    logic        misalign, out_of_range;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_ext, merged;

    always_comb begin
        misalign = ((req_op == OpLh || req_op == OpLhu || req_op == OpSh) && req_addr[0]) ||
                   ((req_op == OpLw || req_op == OpSw) && (req_addr[1:0] != 2'b00));
        out_of_range = ({2'b00, req_addr[31:2]} >= MEM_WORDS);
    end

    // Big-endian lanes: byte offset 0 is the most significant byte.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    lane_byte = mem_data_out[31:24];
            2'd1:    lane_byte = mem_data_out[23:16];
            2'd2:    lane_byte = mem_data_out[15:8];
            default: lane_byte = mem_data_out[7:0];
        endcase
        lane_half = addr_q[1] ? mem_data_out[15:0] : mem_data_out[31:16];
        case (op_q)
            OpLb:    load_ext = {{24{lane_byte[7]}}, lane_byte};
            OpLh:    load_ext = {{16{lane_half[15]}}, lane_half};
            OpLbu:   load_ext = {24'b0, lane_byte};
            OpLhu:   load_ext = {16'b0, lane_half};
            default: load_ext = mem_data_out;
        endcase
    end

    always_comb begin
        merged = mem_data_out;
        if (op_q == OpSb) begin
            case (addr_q[1:0])
                2'd0:    merged[31:24] = wdata_q[7:0];
                2'd1:    merged[23:16] = wdata_q[7:0];
                2'd2:    merged[15:8]  = wdata_q[7:0];
                default: merged[7:0]   = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[15:0] = wdata_q[15:0];
        end else begin
            merged[31:16] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = misalign || out_of_range;
                    if (misalign || out_of_range) state_d = StDone;
                    else if (req_op <= OpLhu)     state_d = StLdRd;
                    else if (req_op == OpSw)      state_d = StStWr;
                    else                          state_d = StRmwRd;
                end
            end
            StLdRd:   state_d = StLdExt;
            StLdExt: begin
                rdata_d = load_ext;
                state_d = StDone;
            end
            StStWr:   state_d = StDone;
            StRmwRd:  state_d = StRmwMrg;
            StRmwMrg: begin
                merge_d = merged;
                state_d = StStWr;
            end
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        // Memory-side outputs are registered so they line up with the state they belong to.
        mem_we_d   = (state_d == StStWr);
        mem_addr_d = (state_d == StLdRd || state_d == StRmwRd || state_d == StStWr) ?
                     {2'b00, addr_d[31:2]} : mem_addr_q;
        mem_din_d  = (state_d == StStWr) ? ((op_d == OpSw) ? wdata_d : merge_d) : mem_din_q;
        done_d     = (state_q == StDone);
        resp_err_d = (state_q == StDone) && err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            op_q       <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            err_q      <= 1'b0;
            merge_q    <= 32'd0;
            rdata_q    <= 32'd0;
            done_q     <= 1'b0;
            resp_err_q <= 1'b0;
            mem_addr_q <= 32'd0;
            mem_we_q   <= 1'b0;
            mem_din_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            merge_q    <= merge_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            resp_err_q <= resp_err_d;
            mem_addr_q <= mem_addr_d;
            mem_we_q   <= mem_we_d;
            mem_din_q  <= mem_din_d;
        end
    end

    assign req_ready        = (state_q == StIdle);
    assign resp_done        = done_q;
    assign resp_error       = resp_err_q;
    assign resp_rdata       = rdata_q;
    assign mem_address      = mem_addr_q;
    assign mem_write_enable = mem_we_q;
    assign mem_data_in      = mem_din_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a one-cycle-latency word memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_done;
    logic        resp_error;
    logic [31:0] resp_rdata;
    logic [31:0] mem_address;
    logic        mem_write_enable;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out = 32'd0;

    logic [31:0] mem [32] = '{default: 32'd0};

    int n_tests = 0;
    int n_fail  = 0;
    int we_cnt  = 0;
    logic [31:0] we_addr = 32'd0;
    int acc_cnt = 0;
    int done_cnt = 0;
    logic [31:0] done_log [64];

    load_store_unit #(.MEM_WORDS(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_done(resp_done), .resp_error(resp_error), .resp_rdata(resp_rdata),
        .mem_address(mem_address), .mem_write_enable(mem_write_enable),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write_enable && mem_address < 32) mem[mem_address[4:0]] <= mem_data_in;
        mem_data_out <= mem[mem_address[4:0]];
    end

    always @(negedge clk) begin
        if (mem_write_enable) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= mem_address;
        end
        if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
        if (resp_done) begin
            done_log[done_cnt % 64] <= resp_rdata;
            done_cnt <= done_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request; returns latency from acceptance cycle to resp_done (0 on timeout).
    task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic err, output int wes);
        int w0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        w0 = we_cnt;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        err = 1'bx;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (resp_done) begin
                lat = n;
                err = resp_error;
                break;
            end
        end
        #1 wes = we_cnt - w0;
    endtask

    initial begin
        int lat;
        logic err;
        int wes;
        logic [2:0]  ops [4];
        logic [31:0] adrs [4];
        logic [31:0] wds [4];
        int k, cyc, a0, d0;
        logic hs;

        rst = 1'b1;
        req_valid = 1'b0;
        req_op = 3'd0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        #22 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_done", {31'd0, resp_done}, 32'd0);
        chk("rst_error", {31'd0, resp_error}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_maddr", mem_address, 32'd0);
        chk("rst_we", {31'd0, mem_write_enable}, 32'd0);
        chk("rst_din", mem_data_in, 32'd0);

        do_req(3'd7, 32'h8, 32'hDEADBEEF, lat, err, wes);
        chk("sw_lat", lat, 3);
        chk("sw_err", {31'd0, err}, 32'd0);
        chk("sw_wes", wes, 1);
        chk("sw_waddr", we_addr, 32'd2);
        chk("sw_mem", mem[2], 32'hDEADBEEF);

        do_req(3'd2, 32'h8, 32'h0, lat, err, wes);
        chk("lw_lat", lat, 4);
        chk("lw_err", {31'd0, err}, 32'd0);
        chk("lw_rdata", resp_rdata, 32'hDEADBEEF);

        do_req(3'd0, 32'h9, 32'h0, lat, err, wes);
        chk("lb9", resp_rdata, 32'hFFFFFFAD);
        do_req(3'd3, 32'h9, 32'h0, lat, err, wes);
        chk("lbu9", resp_rdata, 32'h000000AD);
        do_req(3'd1, 32'hA, 32'h0, lat, err, wes);
        chk("lhA", resp_rdata, 32'hFFFFBEEF);
        do_req(3'd4, 32'h8, 32'h0, lat, err, wes);
        chk("lhu8", resp_rdata, 32'h0000DEAD);
        do_req(3'd0, 32'hB, 32'h0, lat, err, wes);
        chk("lbB", resp_rdata, 32'hFFFFFFEF);
        chk("lbB_lat", lat, 4);

        do_req(3'd5, 32'hB, 32'h12, lat, err, wes);
        chk("sb_lat", lat, 5);
        chk("sb_wes", wes, 1);
        chk("sb_mem", mem[2], 32'hDEADBE12);
        chk("sb_rdata_kept", resp_rdata, 32'hFFFFFFEF);
        do_req(3'd6, 32'h8, 32'h5678, lat, err, wes);
        chk("sh_lat", lat, 5);
        chk("sh_wes", wes, 1);
        chk("sh_mem", mem[2], 32'h5678BE12);

        do_req(3'd2, 32'h6, 32'h0, lat, err, wes);
        chk("e_lw6_lat", lat, 2);
        chk("e_lw6_err", {31'd0, err}, 32'd1);
        chk("e_lw6_wes", wes, 0);
        chk("e_lw6_rdata", resp_rdata, 32'hFFFFFFEF);
        do_req(3'd6, 32'h5, 32'hFFFF, lat, err, wes);
        chk("e_sh5_lat", lat, 2);
        chk("e_sh5_err", {31'd0, err}, 32'd1);
        chk("e_sh5_wes", wes, 0);
        chk("e_sh5_mem", mem[1], 32'd0);
        do_req(3'd2, 32'h80, 32'h0, lat, err, wes);
        chk("e_lw80_lat", lat, 2);
        chk("e_lw80_err", {31'd0, err}, 32'd1);
        chk("e_lw80_rdata", resp_rdata, 32'hFFFFFFEF);

        // Abort an SB during the merge cycle.
        @(negedge clk);
        wes = we_cnt;
        req_valid = 1'b1;
        req_op = 3'd5;
        req_addr = 32'h8;
        req_wdata = 32'hAA;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_wes", we_cnt - wes, 0);
        chk("abort_mem", mem[2], 32'h5678BE12);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_done", {31'd0, resp_done}, 32'd0);
        chk("abort_rdata", resp_rdata, 32'd0);

        // Back-to-back with req_valid held high.
        ops[0] = 3'd7; adrs[0] = 32'h10; wds[0] = 32'h11223344;
        ops[1] = 3'd2; adrs[1] = 32'h10; wds[1] = 32'h0;
        ops[2] = 3'd5; adrs[2] = 32'h11; wds[2] = 32'hAB;
        ops[3] = 3'd3; adrs[3] = 32'h11; wds[3] = 32'h0;
        @(posedge clk);
        #1;
        a0 = acc_cnt;
        d0 = done_cnt;
        k = 0;
        cyc = 0;
        req_valid = 1'b1;
        req_op = ops[0]; req_addr = adrs[0]; req_wdata = wds[0];
        @(negedge clk);
        while (k < 4 && cyc < 200) begin
            hs = req_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                k++;
                if (k < 4) begin
                    req_op = ops[k]; req_addr = adrs[k]; req_wdata = wds[k];
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        for (int i = 0; i < 40 && done_cnt < d0 + 4; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("b2b_accepts", acc_cnt - a0, 4);
        chk("b2b_dones", done_cnt - d0, 4);
        chk("b2b_lw", done_log[(d0 + 1) % 64], 32'h11223344);
        chk("b2b_mem", mem[4], 32'h11AB3344);
        chk("b2b_lbu", done_log[(d0 + 3) % 64], 32'h000000AB);
        chk("b2b_rdata", resp_rdata, 32'h000000AB);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
